alu_exec_seq: RTL and testbench

- Execute-stage ALU that sits directly downstream of aluControl. It consumes the 4-bit aluCtl code together with two operands and produces a registered result and a zero flag.
- Shifts are iterative, one bit per cycle, which keeps the shifter small. All other ops complete in one cycle.
- Uses valid/ready handshakes on both sides so the same block serves the single-cycle core and a later multi-cycle variant.

---
 rtl/alu_exec_seq.sv | 216 +++++++++++++++++++++
 tb/tb_alu_exec_seq.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_seq.sv
// ---------------------------------------------------------------------------
// alu_exec_seq
//
// Execute-stage ALU placed directly after aluControl. It takes the 4-bit
// aluCtl code and two operands and returns a registered result plus a
// registered zero flag. Logic and arithmetic ops finish on the accept edge.
// Shifts advance one bit per clock, so the block needs only a single-bit
// shifter rather than a full barrel shifter.
//
// Only one request may be in flight at a time. A new request is accepted
// only after the previous result has been handed off.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operation request
//   in_ready   block can accept a request (IDLE and not in reset)
//   alu_ctl    operation code from aluControl
//   op_a       operand A (rs1)
//   op_b       operand B (rs2/imm); op_b[SHAMT_W-1:0] is the shift amount
//   out_valid  result available
//   out_ready  consumer accepts result
//   result     registered result
//   zero       registered (result == 0)
//   busy       high while shifting or holding a result
// ---------------------------------------------------------------------------
module alu_exec_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         alu_ctl,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               busy
);

  // aluControl encodings
  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR  = 4'b0001;
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_XOR = 4'b0011;
  localparam logic [3:0] CTL_SLL = 4'b0100;
  localparam logic [3:0] CTL_SRL = 4'b0101;
  localparam logic [3:0] CTL_SUB = 4'b0110;
  localparam logic [3:0] CTL_SLT = 4'b0111;
  localparam logic [3:0] CTL_SRA = 4'b1000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } stateT;

  typedef enum logic [1:0] {
    SH_LEFT        = 2'd0,
    SH_RIGHT_LOGIC = 2'd1,
    SH_RIGHT_ARITH = 2'd2
  } shiftKindT;

  stateT               stateReg,    stateNext;
  shiftKindT           shKindReg,   shKindNext;
  logic [WIDTH-1:0]    accReg,      accNext;
  logic [SHAMT_W-1:0]  cntReg,      cntNext;
  logic [WIDTH-1:0]    resultReg,   resultNext;
  logic                zeroReg,     zeroNext;
  logic                outValidReg, outValidNext;

  // Request decode
  logic [SHAMT_W-1:0]  shamt;
  logic                isShift;
  shiftKindT           reqKind;
  logic [WIDTH-1:0]    aluOut;
  logic                sltBit;
  logic [WIDTH-1:0]    accShifted;

  assign shamt  = op_b[SHAMT_W-1:0];
  assign sltBit = ($signed(op_a) < $signed(op_b));

  // Single-bit shift step for the iterative shifter.
  function automatic logic [WIDTH-1:0] shiftOne(input logic [WIDTH-1:0] v,
                                                input shiftKindT       k);
    logic [WIDTH-1:0] r;
    case (k)
      SH_LEFT:        r = {v[WIDTH-2:0], 1'b0};
      SH_RIGHT_LOGIC: r = {1'b0, v[WIDTH-1:1]};
      default:        r = {v[WIDTH-1], v[WIDTH-1:1]};
    endcase
    return r;
  endfunction

  assign accShifted = shiftOne(accReg, shKindReg);

  // Single-cycle result. For shifts this is op_a, which is also the correct
  // answer when the shift amount is zero, so the IDLE logic can use aluOut
  // for every op that finishes on the accept edge.
  always_comb begin
    aluOut  = op_a + op_b;
    isShift = 1'b0;
    reqKind = SH_LEFT;
    case (alu_ctl)
      CTL_ADD: aluOut = op_a + op_b;
      CTL_SUB: aluOut = op_a - op_b;
      CTL_AND: aluOut = op_a & op_b;
      CTL_OR:  aluOut = op_a | op_b;
      CTL_XOR: aluOut = op_a ^ op_b;
      CTL_SLT: aluOut = {{(WIDTH-1){1'b0}}, sltBit};
      CTL_SLL: begin
        aluOut  = op_a;
        isShift = 1'b1;
        reqKind = SH_LEFT;
      end
      CTL_SRL: begin
        aluOut  = op_a;
        isShift = 1'b1;
        reqKind = SH_RIGHT_LOGIC;
      end
      CTL_SRA: begin
        aluOut  = op_a;
        isShift = 1'b1;
        reqKind = SH_RIGHT_ARITH;
      end
      default: aluOut = op_a + op_b;  // unknown codes behave as ADD
    endcase
  end

  // State register and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg    <= IDLE;
      shKindReg   <= SH_LEFT;
      accReg      <= '0;
      cntReg      <= '0;
      resultReg   <= '0;
      zeroReg     <= 1'b0;
      outValidReg <= 1'b0;
    end else begin
      stateReg    <= stateNext;
      shKindReg   <= shKindNext;
      accReg      <= accNext;
      cntReg      <= cntNext;
      resultReg   <= resultNext;
      zeroReg     <= zeroNext;
      outValidReg <= outValidNext;
    end
  end

  // Next-state and datapath update
  always_comb begin
    stateNext    = stateReg;
    shKindNext   = shKindReg;
    accNext      = accReg;
    cntNext      = cntReg;
    resultNext   = resultReg;
    zeroNext     = zeroReg;
    outValidNext = outValidReg;

    case (stateReg)
      IDLE: begin
        // in_ready is just "IDLE and out of reset"; while in reset the
        // registers are held, so in_valid alone qualifies the accept here.
        if (in_valid) begin
          if (isShift && (shamt != '0)) begin
            accNext    = op_a;
            cntNext    = shamt;
            shKindNext = reqKind;
            stateNext  = SHIFT;
          end else begin
            resultNext   = aluOut;
            zeroNext     = (aluOut == '0);
            outValidNext = 1'b1;
            stateNext    = DONE;
          end
        end
      end

      SHIFT: begin
        accNext = accShifted;
        cntNext = cntReg - SHAMT_W'(1);
        // Last step: publish the shifted value on the same edge.
        if (cntReg == SHAMT_W'(1)) begin
          resultNext   = accShifted;
          zeroNext     = (accShifted == '0);
          outValidNext = 1'b1;
          stateNext    = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          outValidNext = 1'b0;
          stateNext    = IDLE;
        end
      end

      default: begin
        stateNext    = IDLE;
        outValidNext = 1'b0;
      end
    endcase
  end

  assign in_ready  = (stateReg == IDLE) && rst_n;
  assign busy      = (stateReg != IDLE);
  assign out_valid = outValidReg;
  assign result    = resultReg;
  assign zero      = zeroReg;

endmodule

// File: tb/tb_alu_exec_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_seq
//
// Self-checking bench for alu_exec_seq. The driver issues requests and pushes
// the expected result, zero flag and latency, all computed from plain
// arithmetic, into a scoreboard queue. A monitor on the falling edge compares
// every cycle in which out_valid is high against the head of the queue and
// pops the entry on each output handshake.
// ---------------------------------------------------------------------------
module tb_alu_exec_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        busy;

  alu_exec_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctl   (alu_ctl),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        z;
    int          lat;
    int          acc;
  } expT;

  expT expQ[$];
  int  nChecks = 0;
  int  nFail   = 0;
  int  cyc     = 0;
  bit  randReady = 1'b0;
  bit  seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: shifts are whole-amount operators here.
  function automatic void model(input logic [3:0] c, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] r,
                                output int lat);
    int n;
    n   = int'(b[4:0]);
    lat = 0;
    case (c)
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0011: r = a ^ b;
      4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0100: begin r = a << n;            lat = n; end
      4'b0101: begin r = a >> n;            lat = n; end
      4'b1000: begin r = $signed(a) >>> n;  lat = n; end
      default: r = a + b;
    endcase
  endfunction

  // Issue one request; returns #1 after the accept edge with the
  // expectation already queued.
  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    int g = 0;
    logic [31:0] r;
    int lat;
    while (!in_ready) begin
      @(posedge clk); #1;
      g++;
      if (g > 300) begin
        nChecks++; nFail++;
        $display("FAIL issue_timeout: in_ready stayed 0 for %0d cycles, required 1", g);
        return;
      end
    end
    in_valid = 1'b1; alu_ctl = c; op_a = a; op_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    model(c, a, b, r, lat);
    expQ.push_back('{res: r, z: (r == 32'd0), lat: lat, acc: cyc});
    $display("issue ctl=%b a=%08h b=%08h exp=%08h lat=%0d", c, a, b, r, lat);
    // Operands are don't-care after the accept edge.
    op_a = $urandom; op_b = $urandom; alu_ctl = 4'($urandom_range(0, 15));
  endtask

  task automatic drain();
    int g = 0;
    while ((expQ.size() != 0 || !in_ready) && g < 400) begin
      @(posedge clk); #1;
      g++;
    end
    check("drain_timeout", 64'(g >= 400), 64'd0);
  endtask

  // Random backpressure
  initial begin
    forever begin
      @(posedge clk); #1;
      if (randReady) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
    end else if (out_valid) begin
      if (expQ.size() == 0) begin
        nChecks++; nFail++;
        $display("FAIL spurious_out_valid: got out_valid=1 result=%08h, required no output", result);
      end else begin
        if (!seen) begin
          seen = 1'b1;
          check("latency", 64'(cyc - expQ[0].acc), 64'(expQ[0].lat));
        end
        check("result", 64'(result), 64'(expQ[0].res));
        check("zero", 64'(zero), 64'(expQ[0].z));
        if (out_ready) begin
          $display("result %08h zero=%0b", result, zero);
          void'(expQ.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_ctl = 4'd0; op_a = 32'd0; op_b = 32'd0;

    // Reset values
    repeat (3) @(posedge clk); #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_zero", 64'(zero), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_in_ready", 64'(in_ready), 64'd1);

    // 1. ADD 5+7 with out_ready high
    out_ready = 1'b1;
    issue(4'b0010, 32'd5, 32'd7);
    check("add_out_valid", 64'(out_valid), 64'd1);
    check("add_result", 64'(result), 64'd12);
    check("add_zero", 64'(zero), 64'd0);
    check("add_in_ready_low", 64'(in_ready), 64'd0);
    check("add_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    check("add_in_ready_back", 64'(in_ready), 64'd1);
    check("add_out_valid_clr", 64'(out_valid), 64'd0);

    // 2. SUB to zero, signed SLT, unknown code
    issue(4'b0110, 32'd3, 32'd3);
    issue(4'b0111, 32'hFFFF_FFFF, 32'd1);
    issue(4'b1111, 32'd2, 32'd2);
    drain();

    // 3. SRA by 4 with in_valid held high during the shift
    issue(4'b1000, 32'h8000_0000, 32'd4);
    in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      check("sra_valid_low", 64'(out_valid), 64'd0);
      check("sra_busy", 64'(busy), 64'd1);
      check("sra_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("sra_valid_edge4", 64'(out_valid), 64'd1);
    check("sra_result", 64'(result), 64'hF800_0000);
    check("sra_busy_done", 64'(busy), 64'd1);
    drain();
    issue(4'b0101, 32'h8000_0000, 32'd4);
    issue(4'b0100, 32'd1, 32'h25);
    drain();

    // 4. Shift amount 0 (upper op_b bits ignored) and amount 31
    issue(4'b0100, 32'hA5, 32'h40);
    issue(4'b0101, 32'h8000_0000, 32'd31);
    drain();

    // 5. Backpressure on AND
    out_ready = 1'b0;
    issue(4'b0000, 32'h0000_F0F0, 32'h0000_0FF0);
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_result", 64'(result), 64'h0000_00F0);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_done_valid", 64'(out_valid), 64'd0);
    check("bp_done_ready", 64'(in_ready), 64'd1);

    // 6. Asynchronous reset mid-shift
    issue(4'b0100, 32'h0000_0003, 32'd20);
    repeat (7) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_result", 64'(result), 64'd0);
    check("abort_zero", 64'(zero), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd0);
    expQ.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_valid", 64'(out_valid), 64'd0);
    check("post_rst_ready", 64'(in_ready), 64'd1);
    issue(4'b0010, 32'd1, 32'd1);
    drain();

    // 7. Randomized traffic with random backpressure
    randReady = 1'b1;
    for (int t = 0; t < 150; t++) begin
      logic [3:0]  c;
      logic [31:0] a, b;
      c = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) == 0) b = a;
      if ($urandom_range(0, 7) == 0) a = 32'd0;
      issue(c, a, b);
    end
    out_ready = 1'b1;
    drain();
    randReady = 1'b0;
    out_ready = 1'b1;
    drain();
    check("queue_empty", 64'(expQ.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
